// File: rtl/max_unpool_stream.sv
// max_unpool_stream
//   Streaming max-unpooling stage. Takes one pooled value and the position of
//   that maximum inside its POOL_SIZE-element window, then emits the window
//   serially: the value at the argmax position and zero everywhere else.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   upstream value/index valid
//   o_in_ready   block accepts an input this cycle
//   i_in_data    signed pooled (max) value, DATA_BITS wide
//   i_in_idx     argmax position within the window
//   o_out_valid  output beat valid
//   i_out_ready  downstream accepts the beat
//   o_out_data   signed unpooled element
//   o_out_pos    position of the current beat, 0..POOL_SIZE-1
//   o_out_last   high on the beat at position POOL_SIZE-1
//   o_idx_err    one-cycle pulse after accepting an index >= POOL_SIZE
module max_unpool_stream #(
  parameter int DATA_BITS = 8,
  parameter int POOL_SIZE = 4,
  parameter int IDX_BITS  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [DATA_BITS-1:0] i_in_data,
  input  logic [IDX_BITS-1:0]  i_in_idx,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [DATA_BITS-1:0] o_out_data,
  output logic [IDX_BITS-1:0]  o_out_pos,
  output logic                 o_out_last,
  output logic                 o_idx_err
);

  // One extra bit so POOL_SIZE == 2^IDX_BITS is representable in the compare.
  localparam logic [IDX_BITS:0]   LP_POOL = (IDX_BITS+1)'(POOL_SIZE);
  localparam logic [IDX_BITS-1:0] LP_LAST = IDX_BITS'(POOL_SIZE - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_val;
  logic [IDX_BITS-1:0]  r_idx;
  logic                 r_out_valid;
  logic [DATA_BITS-1:0] r_out_data;
  logic [IDX_BITS-1:0]  r_out_pos;
  logic                 r_out_last;
  logic                 r_idx_err;

  logic                 w_out_xfer;
  logic                 w_in_xfer;
  logic [IDX_BITS-1:0]  w_pos_next;

  assign w_out_xfer = r_out_valid & i_out_ready;

  // A new window can be taken while idle, or on the final beat of the current
  // window so consecutive windows stream without a bubble. This makes in_ready
  // combinationally dependent on out_ready by design. Held low during reset.
  assign o_in_ready = i_rst_n &
                      ((r_state == ST_IDLE) | (w_out_xfer & r_out_last));
  assign w_in_xfer  = i_in_valid & o_in_ready;
  assign w_pos_next = r_out_pos + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_val       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_pos   <= '0;
      r_out_last  <= 1'b0;
      r_idx_err   <= 1'b0;
    end else begin
      r_idx_err <= 1'b0;
      if (w_in_xfer) begin
        // Start a window: first beat is position 0. An out-of-range index never
        // matches any position, so that window comes out as all zeros.
        r_state     <= ST_EMIT;
        r_val       <= i_in_data;
        r_idx       <= i_in_idx;
        r_out_valid <= 1'b1;
        r_out_pos   <= '0;
        r_out_data  <= (i_in_idx == '0) ? i_in_data : '0;
        r_out_last  <= 1'b0;
        r_idx_err   <= ({1'b0, i_in_idx} >= LP_POOL);
      end else if (r_state == ST_EMIT && w_out_xfer) begin
        if (r_out_last) begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_out_pos   <= '0;
          r_out_data  <= '0;
          r_out_last  <= 1'b0;
        end else begin
          r_out_pos  <= w_pos_next;
          r_out_data <= (w_pos_next == r_idx) ? r_val : '0;
          r_out_last <= (w_pos_next == LP_LAST);
        end
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_pos   = r_out_pos;
  assign o_out_last  = r_out_last;
  assign o_idx_err   = r_idx_err;

endmodule

// File: tb/tb_max_unpool_stream.sv
// Directed testbench for max_unpool_stream: a POOL_SIZE=4 instance for the
// main windows and a POOL_SIZE=3 instance for the out-of-range index case.
module tb_max_unpool_stream;

  logic       clk;
  logic       rst_n;

  // POOL_SIZE = 4 instance
  logic       in_valid, in_ready, out_valid, out_ready, out_last, idx_err;
  logic [7:0] in_data, out_data;
  logic [1:0] in_idx, out_pos;

  // POOL_SIZE = 3 instance
  logic       in_valid3, in_ready3, out_valid3, out_ready3, out_last3, idx_err3;
  logic [7:0] in_data3, out_data3;
  logic [1:0] in_idx3, out_pos3;

  int n_vec = 0;
  int n_err = 0;

  max_unpool_stream #(.DATA_BITS(8), .POOL_SIZE(4), .IDX_BITS(2)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_idx(in_idx),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_pos(out_pos),
    .o_out_last(out_last), .o_idx_err(idx_err)
  );

  max_unpool_stream #(.DATA_BITS(8), .POOL_SIZE(3), .IDX_BITS(2)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid3), .o_in_ready(in_ready3),
    .i_in_data(in_data3), .i_in_idx(in_idx3),
    .o_out_valid(out_valid3), .i_out_ready(out_ready3),
    .o_out_data(out_data3), .o_out_pos(out_pos3),
    .o_out_last(out_last3), .o_idx_err(idx_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat4(input string tag, input logic [1:0] pos, input logic [7:0] data,
                       input logic last);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".pos"},   32'(out_pos),   32'(pos));
    chk({tag, ".data"},  32'(out_data),  32'(data));
    chk({tag, ".last"},  32'(out_last),  32'(last));
    $display("beat %s pos=%0d data=%0h last=%0b", tag, out_pos, out_data, out_last);
  endtask

  task automatic beat3(input string tag, input logic [1:0] pos, input logic [7:0] data,
                       input logic last);
    chk({tag, ".valid"}, 32'(out_valid3), 32'd1);
    chk({tag, ".pos"},   32'(out_pos3),   32'(pos));
    chk({tag, ".data"},  32'(out_data3),  32'(data));
    chk({tag, ".last"},  32'(out_last3),  32'(last));
    $display("beat %s pos=%0d data=%0h last=%0b", tag, out_pos3, out_data3, out_last3);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_data = 0; in_idx = 0; out_ready = 0;
    in_valid3 = 0; in_data3 = 0; in_idx3 = 0; out_ready3 = 0;
    #1;
    // Asynchronous reset values before any clock edge
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    chk("rst.out_pos",   32'(out_pos),   32'd0);
    chk("rst.out_last",  32'(out_last),  32'd0);
    chk("rst.idx_err",   32'(idx_err),   32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    $display("reset released");

    // ---- Single window: 57 at idx 2 ----
    in_valid = 1; in_data = 8'd57; in_idx = 2; out_ready = 1;
    tick();
    in_valid = 0;
    beat4("w1.p0", 2'd0, 8'h00, 1'b0);
    chk("w1.idx_err", 32'(idx_err), 32'd0);
    chk("w1.in_ready_busy", 32'(in_ready), 32'd0);
    tick(); beat4("w1.p1", 2'd1, 8'h00, 1'b0);
    tick(); beat4("w1.p2", 2'd2, 8'h39, 1'b0);
    tick(); beat4("w1.p3", 2'd3, 8'h00, 1'b1);
    chk("w1.in_ready_last", 32'(in_ready), 32'd1);
    tick();
    chk("w1.idle_valid", 32'(out_valid), 32'd0);
    chk("w1.idle_ready", 32'(in_ready), 32'd1);

    // ---- Negative max, back-to-back: (-3, 0) then (-128, 3) ----
    in_valid = 1; in_data = 8'hFD; in_idx = 0;
    tick();
    in_data = 8'h80; in_idx = 3;   // second window offered continuously
    beat4("bb.p0", 2'd0, 8'hFD, 1'b0);
    tick(); beat4("bb.p1", 2'd1, 8'h00, 1'b0);
    tick(); beat4("bb.p2", 2'd2, 8'h00, 1'b0);
    tick(); beat4("bb.p3", 2'd3, 8'h00, 1'b1);
    chk("bb.in_ready_last", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0;
    beat4("bb.p4", 2'd0, 8'h00, 1'b0);
    tick(); beat4("bb.p5", 2'd1, 8'h00, 1'b0);
    tick(); beat4("bb.p6", 2'd2, 8'h00, 1'b0);
    tick(); beat4("bb.p7", 2'd3, 8'h80, 1'b1);
    tick();
    chk("bb.idle_valid", 32'(out_valid), 32'd0);

    // ---- Backpressure: 12 at idx 1, stall 3 cycles at pos 1 ----
    in_valid = 1; in_data = 8'd12; in_idx = 1;
    tick();
    in_valid = 0;
    beat4("bp.p0", 2'd0, 8'h00, 1'b0);
    tick();
    beat4("bp.p1", 2'd1, 8'h0C, 1'b0);
    out_ready = 0;
    in_valid = 1; in_data = 8'd77; in_idx = 0;   // must be ignored while busy
    #1;
    chk("bp.in_ready_stall", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      beat4("bp.hold", 2'd1, 8'h0C, 1'b0);
      chk("bp.in_ready_hold", 32'(in_ready), 32'd0);
    end
    in_valid = 0; out_ready = 1;
    tick(); beat4("bp.p2", 2'd2, 8'h00, 1'b0);
    tick(); beat4("bp.p3", 2'd3, 8'h00, 1'b1);
    tick();
    chk("bp.idle_valid", 32'(out_valid), 32'd0);

    // ---- Invalid index on POOL_SIZE=3 instance: 99 at idx 3 ----
    chk("ie.in_ready", 32'(in_ready3), 32'd1);
    in_valid3 = 1; in_data3 = 8'd99; in_idx3 = 3; out_ready3 = 1;
    tick();
    in_valid3 = 0;
    chk("ie.err_pulse", 32'(idx_err3), 32'd1);
    beat3("ie.p0", 2'd0, 8'h00, 1'b0);
    tick();
    chk("ie.err_clear", 32'(idx_err3), 32'd0);
    beat3("ie.p1", 2'd1, 8'h00, 1'b0);
    tick();
    beat3("ie.p2", 2'd2, 8'h00, 1'b1);
    tick();
    chk("ie.idle_valid", 32'(out_valid3), 32'd0);
    chk("ie.idle_err", 32'(idx_err3), 32'd0);

    // ---- Reset mid-window, then window (5, idx 0) ----
    in_valid = 1; in_data = 8'd33; in_idx = 1;
    tick();
    in_valid = 0;
    tick();
    beat4("rm.p1", 2'd1, 8'd33, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm.out_valid", 32'(out_valid), 32'd0);
    chk("rm.out_pos",   32'(out_pos),   32'd0);
    chk("rm.out_data",  32'(out_data),  32'd0);
    chk("rm.idx_err",   32'(idx_err),   32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rm.in_ready", 32'(in_ready), 32'd1);
    chk("rm.idle_valid", 32'(out_valid), 32'd0);
    in_valid = 1; in_data = 8'd5; in_idx = 0;
    tick();
    in_valid = 0;
    beat4("rm.n0", 2'd0, 8'h05, 1'b0);
    tick(); beat4("rm.n1", 2'd1, 8'h00, 1'b0);
    tick(); beat4("rm.n2", 2'd2, 8'h00, 1'b0);
    tick(); beat4("rm.n3", 2'd3, 8'h00, 1'b1);
    tick();
    chk("rm.idle_valid_end", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
